bus_arbiter_rr: RTL and testbench
=================================

# bus_arbiter_rr

Parametrised N-port round-robin bus arbiter that owns the single shared Sysbus request/response channel on behalf of the instruction-fetch, data-memory and any future bus masters (page-table walker, DMA). It generalises the two-port icache/dcache arbitration to NUM_PORTS requesters with fair rotation, registered grants, a mandatory turnaround cycle and an optional hold-limit revocation. It sits beside the top-level pipeline; each master raises busreq, waits for busgrant, drives the bus, then signals busidle.

## Interface
- NUM_PORTS, 2, number of requesting masters (>= 2, need not be a power of two)
- HOLD_LIMIT, 64, maximum grant duration in cycles before revocation (used only with ARB_HOLD_LIMIT_EN, >= 1)
- IDW, $clog2(NUM_PORTS), width of grant_id (derived, not overridden)

- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- busreq  input  NUM_PORTS  per-master request, level
- busidle  input  NUM_PORTS  per-master "no bus transaction outstanding", level
- busgrant  output  NUM_PORTS  one-hot registered grant; at most one bit set
- grant_valid  output  1  OR of busgrant, registered
- grant_id  output  IDW  index of current owner; holds last owner when grant_valid=0
- busrevoke  output  NUM_PORTS  one-hot request to current owner to finish and release; constant 0 without ARB_HOLD_LIMIT_EN

## Operation
- Reset: busgrant=0, grant_valid=0, grant_id=0, busrevoke=0, state=IDLE, rr pointer=NUM_PORTS-1 (port 0 wins first), hold counter=0.
- States: IDLE, GRANT, REVOKE, GAP.
- IDLE: if any busreq bit is set, pick first set bit scanning pointer+1, pointer+2, ... modulo NUM_PORTS; register busgrant[winner]=1, grant_id=winner, pointer=winner; go GRANT. No request: stay.
- GRANT: owner keeps grant while busreq[owner]=1 or busidle[owner]=0. When busreq[owner]=0 and busidle[owner]=1 are sampled together, clear busgrant next cycle, go GAP.
- GAP: one dead bus-turnaround cycle with no grant; then IDLE. Minimum one cycle with grant_valid=0 between any two grants, including back-to-back grants to the same port.
- Requests of non-owners are ignored until IDLE; withdrawing a request before being granted is legal and loses nothing.
- A master whose busreq drops on the same edge its grant rises still holds the grant until the release condition is seen (earliest the following cycle).
- Rotation is strictly fair: with all ports requesting continuously, grants cycle 0,1,...,N-1,0.
- Hold counter (macro build only): cleared on entering GRANT, increments each cycle in GRANT, saturates. When it reaches HOLD_LIMIT, assert busrevoke[owner], go REVOKE.
- REVOKE: busgrant stays asserted; release as soon as busidle[owner]=1 regardless of busreq[owner]; busrevoke and busgrant clear together, go GAP. Pointer already at owner, so owner is served last in the next rotation.
- Reset mid-grant: all outputs return to reset values on the next edge; in-flight bus transaction is abandoned (masters reset on the same signal).
- X on busreq/busidle of non-owners while in GRANT must not affect outputs.

## Timing
- Request-to-grant latency: request sampled in IDLE at edge t, busgrant high after edge t (visible cycle t+1); 1 cycle best case.
- Release-to-next-grant: release sampled at edge t, busgrant low after t, GAP cycle, next grant visible after edge t+2.
- Revocation: busrevoke rises exactly HOLD_LIMIT cycles after busgrant rose; grant drops one cycle after busidle[owner]=1 sampled.
- All outputs registered; no combinational input-to-output path.

## Configuration
- ARB_HOLD_LIMIT_EN defined: hold counter, REVOKE state and busrevoke are built; grants are forcibly ended after HOLD_LIMIT cycles once the owner reaches idle.
- ARB_HOLD_LIMIT_EN undefined: no counter or REVOKE state; busrevoke tied to 0; a grant lasts until voluntary release; HOLD_LIMIT is ignored.

## Test plan
- Reset then busreq=2'b11 (NUM_PORTS=2) held -> grant to port 0 one cycle later; on port 0 release (req=0, idle=1), one GAP cycle, then grant to port 1.
- NUM_PORTS=3, all requesting, each owner releases after 4 cycles -> grant_id sequence 0,1,2,0,1,2 with exactly one grant_valid=0 cycle between grants.
- Owner drops busreq while busidle=0 for 5 cycles -> grant held those 5 cycles, drops one cycle after busidle=1.
- Assert reset during GRANT of port 1 -> next cycle busgrant=0, grant_valid=0, grant_id=0; subsequent simultaneous requests granted to port 0.
- ARB_HOLD_LIMIT_EN, HOLD_LIMIT=8, port 0 requests forever with idle=0 until cycle 12 -> busrevoke[0] rises 8 cycles after grant, grant drops one cycle after idle=1, waiting port 1 granted after the GAP cycle.
- Without macro, same stimulus -> busrevoke stays 0, port 0 keeps grant until it voluntarily releases.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-port round-robin owner arbiter for the shared Sysbus channel.
// Latency: request sampled in IDLE -> registered grant next cycle; release -> 1 dead GAP cycle -> next grant.
// Backpressure: owner holds the bus until it drops busreq while idle; non-owners wait (requests ignored) until IDLE.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   busreq[N]       per-master request level
//   busidle[N]      per-master "no transaction outstanding" level
//   busgrant[N]     one-hot registered grant
//   grant_valid     OR of busgrant (registered)
//   grant_id[IDW]   index of current owner, holds last owner while no grant
//   busrevoke[N]    one-hot "finish and release" to the owner (hold-limit build only, else 0)
//
// Optional feature: define ARB_HOLD_LIMIT_EN to build the hold counter, REVOKE state and busrevoke.

module bus_arbiter_rr #(
  parameter int NUM_PORTS  = 2,
  parameter int HOLD_LIMIT = 64,
  localparam int IDW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] busreq,
  input  logic [NUM_PORTS-1:0] busidle,
  output logic [NUM_PORTS-1:0] busgrant,
  output logic                 grant_valid,
  output logic [IDW-1:0]       grant_id,
  output logic [NUM_PORTS-1:0] busrevoke
);

  if (NUM_PORTS < 2 || HOLD_LIMIT < 1) begin : g_param_check
    $error("bus_arbiter_rr: NUM_PORTS must be >= 2 and HOLD_LIMIT >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    REVOKE = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;        // last winner; scanning starts one past it
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic           owner_release;

  // Round-robin pick: ports above the pointer first (ascending), then wrap
  // to ports at or below it. The previous winner is therefore served last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!win_found && busreq[i] && (IDW'(i) > ptr)) begin
        win_found = 1'b1;
        win_idx   = IDW'(i);
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!win_found && busreq[i] && (IDW'(i) <= ptr)) begin
        win_found = 1'b1;
        win_idx   = IDW'(i);
      end
    end
  end

  // Only the owner's lines are looked at, so non-owner X cannot leak in.
  assign owner_release = !busreq[grant_id] && busidle[grant_id];

`ifdef ARB_HOLD_LIMIT_EN
  localparam int CW = $clog2(HOLD_LIMIT + 1);
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] hold_cnt_nxt;

  assign hold_cnt_nxt = (hold_cnt >= CW'(HOLD_LIMIT)) ? hold_cnt : hold_cnt + 1'b1;
`else
  assign busrevoke = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= IDW'(NUM_PORTS - 1);
      busgrant    <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
`ifdef ARB_HOLD_LIMIT_EN
      busrevoke   <= '0;
      hold_cnt    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            busgrant    <= NUM_PORTS'(1) << win_idx;
            grant_valid <= 1'b1;
            grant_id    <= win_idx;
            ptr         <= win_idx;
            state       <= GRANT;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt    <= '0;
`endif
          end
        end
        GRANT: begin
          if (owner_release) begin
            busgrant    <= '0;
            grant_valid <= 1'b0;
            state       <= GAP;
          end
`ifdef ARB_HOLD_LIMIT_EN
          else begin
            hold_cnt <= hold_cnt_nxt;
            // Voluntary release wins over revocation on the same edge.
            if (hold_cnt_nxt >= CW'(HOLD_LIMIT)) begin
              busrevoke <= busgrant;
              state     <= REVOKE;
            end
          end
`endif
        end
        REVOKE: begin
`ifdef ARB_HOLD_LIMIT_EN
          // Owner was told to wrap up; release on idle regardless of busreq.
          if (busidle[grant_id]) begin
            busgrant    <= '0;
            grant_valid <= 1'b0;
            busrevoke   <= '0;
            state       <= GAP;
          end
`else
          state <= GAP;
`endif
        end
        default: begin
          // GAP: one turnaround cycle with no owner.
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Testbench for bus_arbiter_rr with NUM_PORTS=3, HOLD_LIMIT=8.
// Directed vector table, hand-written multi-cycle sequences, then random
// stimulus against an owner/queue-level reference model.
module tb_bus_arbiter_rr;
  localparam int N  = 3;
  localparam int HL = 8;

  logic         clk;
  logic         reset;
  logic [N-1:0] busreq;
  logic [N-1:0] busidle;
  logic [N-1:0] busgrant;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic [N-1:0] busrevoke;

  bus_arbiter_rr #(.NUM_PORTS(N), .HOLD_LIMIT(HL)) dut (
    .clk(clk), .reset(reset), .busreq(busreq), .busidle(busidle),
    .busgrant(busgrant), .grant_valid(grant_valid), .grant_id(grant_id),
    .busrevoke(busrevoke)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the bus (-1 = nobody), whether we are in the
  // turnaround cycle, the last winner, cycles held and revocation flag.
  int m_owner = -1;
  int m_ptr   = N - 1;
  int m_id    = 0;
  int m_held  = 0;
  bit m_gap   = 1'b0;
  bit m_rev   = 1'b0;

  task automatic model_edge();
    if (reset === 1'b1) begin
      m_owner = -1; m_ptr = N - 1; m_id = 0; m_held = 0; m_gap = 0; m_rev = 0;
    end else if (m_gap) begin
      m_gap = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_owner < 0 && busreq[c] === 1'b1) begin
          m_owner = c; m_ptr = c; m_id = c; m_held = 0;
        end
      end
    end else if (m_rev) begin
      if (busidle[m_owner] === 1'b1) begin
        m_owner = -1; m_rev = 0; m_gap = 1;
      end
    end else if (busreq[m_owner] === 1'b0 && busidle[m_owner] === 1'b1) begin
      m_owner = -1; m_gap = 1;
    end else begin
      m_held++;
`ifdef ARB_HOLD_LIMIT_EN
      if (m_held == HL) m_rev = 1;
`endif
    end
  endtask

  task automatic check_exp(input string tag, input logic [N-1:0] eg, input logic ev,
                           input logic [1:0] eid, input logic [N-1:0] er);
    vectors++;
    if (busgrant !== eg || grant_valid !== ev || grant_id !== eid || busrevoke !== er) begin
      miscompares++;
      $display("FAIL %s: got grant=%b valid=%b id=%0d revoke=%b, want grant=%b valid=%b id=%0d revoke=%b",
               tag, busgrant, grant_valid, grant_id, busrevoke, eg, ev, eid, er);
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg;
    logic [N-1:0] er;
    logic [1:0]   eid;
    eg  = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
    er  = m_rev ? eg : 3'b000;
    eid = m_id[1:0];
    check_exp(tag, eg, (m_owner >= 0), eid, er);
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // Apply current inputs for one edge, then compare against the model.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] idle;
    logic [N-1:0] eg;
    logic         ev;
    logic [1:0]   eid;
    logic [N-1:0] er;
  } vec_t;

  vec_t tbl [20];

  initial begin
    int g0_cyc, drop_cyc, g1_cyc, rev_cyc;
    reset = 1'b1; busreq = '0; busidle = '1;

    //            rst   req     idle    grant   vld   id     revoke
    tbl[0]  = '{1'b1, 3'b000, 3'b111, 3'b000, 1'b0, 2'd0, 3'b000};
    tbl[1]  = '{1'b0, 3'b011, 3'b111, 3'b001, 1'b1, 2'd0, 3'b000};
    tbl[2]  = '{1'b0, 3'b011, 3'b110, 3'b001, 1'b1, 2'd0, 3'b000};
    tbl[3]  = '{1'b0, 3'b010, 3'b111, 3'b000, 1'b0, 2'd0, 3'b000};
    tbl[4]  = '{1'b0, 3'b010, 3'b111, 3'b000, 1'b0, 2'd0, 3'b000};
    tbl[5]  = '{1'b0, 3'b010, 3'b111, 3'b010, 1'b1, 2'd1, 3'b000};
    tbl[6]  = '{1'b0, 3'b101, 3'b111, 3'b000, 1'b0, 2'd1, 3'b000};
    tbl[7]  = '{1'b0, 3'b101, 3'b111, 3'b000, 1'b0, 2'd1, 3'b000};
    tbl[8]  = '{1'b0, 3'b101, 3'b111, 3'b100, 1'b1, 2'd2, 3'b000};
    tbl[9]  = '{1'b0, 3'b001, 3'b011, 3'b100, 1'b1, 2'd2, 3'b000};
    tbl[10] = '{1'b0, 3'b001, 3'b111, 3'b000, 1'b0, 2'd2, 3'b000};
    tbl[11] = '{1'b0, 3'b000, 3'b111, 3'b000, 1'b0, 2'd2, 3'b000};
    tbl[12] = '{1'b0, 3'b000, 3'b111, 3'b000, 1'b0, 2'd2, 3'b000};
    tbl[13] = '{1'b0, 3'b100, 3'b111, 3'b100, 1'b1, 2'd2, 3'b000};
    tbl[14] = '{1'b0, 3'b000, 3'b111, 3'b000, 1'b0, 2'd2, 3'b000};
    tbl[15] = '{1'b0, 3'b100, 3'b111, 3'b000, 1'b0, 2'd2, 3'b000};
    tbl[16] = '{1'b0, 3'b100, 3'b111, 3'b100, 1'b1, 2'd2, 3'b000};
    tbl[17] = '{1'b1, 3'b100, 3'b111, 3'b000, 1'b0, 2'd0, 3'b000};
    tbl[18] = '{1'b0, 3'b110, 3'b111, 3'b010, 1'b1, 2'd1, 3'b000};
    tbl[19] = '{1'b1, 3'b110, 3'b111, 3'b000, 1'b0, 2'd0, 3'b000};

    for (int v = 0; v < 20; v++) begin
      reset = tbl[v].rst; busreq = tbl[v].req; busidle = tbl[v].idle;
      @(posedge clk);
      model_edge();
      #1;
      check_exp($sformatf("tbl%0d", v), tbl[v].eg, tbl[v].ev, tbl[v].eid, tbl[v].er);
    end

    // Owner drops busreq but stays busy for 5 cycles; non-owner lines are X.
    reset = 1'b1; busreq = '0; busidle = '1; step("hold_rst");
    reset = 1'b0; busreq = 3'b001; step("hold_grant");
    for (int k = 0; k < 5; k++) begin
      busreq = {2'bxx, 1'b0}; busidle = {2'bxx, 1'b0};
      step($sformatf("hold_busy%0d", k));
      check_exp("hold_kept", 3'b001, 1'b1, 2'd0, 3'b000);
    end
    busreq = {2'bxx, 1'b0}; busidle = {2'bxx, 1'b1}; step("hold_release");
    check_exp("hold_dropped", 3'b000, 1'b0, 2'd0, 3'b000);
    busreq = '0; busidle = '1; step("hold_gap"); step("hold_idle");

    // Long hold: port 0 requests with idle low until cycle 12, port 1 waits.
    reset = 1'b1; step("lim_rst");
    reset = 1'b0;
    g0_cyc = -1; drop_cyc = -1; g1_cyc = -1; rev_cyc = -1;
    for (int c = 0; c < 24; c++) begin
      busreq  = {1'b0, 1'b1, (c < 16) ? 1'b1 : 1'b0};
      busidle = {1'b1, 1'b1, (c >= 12) ? 1'b1 : 1'b0};
      step($sformatf("lim_c%0d", c));
      if (g0_cyc < 0 && busgrant[0]) g0_cyc = c;
      if (g0_cyc >= 0 && drop_cyc < 0 && !busgrant[0]) drop_cyc = c;
      if (g1_cyc < 0 && busgrant[1]) g1_cyc = c;
      if (rev_cyc < 0 && busrevoke[0]) rev_cyc = c;
    end
    check_int("lim_grant0_cycle", g0_cyc, 0);
`ifdef ARB_HOLD_LIMIT_EN
    check_int("lim_revoke_cycle", rev_cyc, g0_cyc + HL);
    check_int("lim_drop_cycle", drop_cyc, 12);
    check_int("lim_grant1_cycle", g1_cyc, 14);
`else
    check_int("lim_revoke_never", rev_cyc, -1);
    check_int("lim_drop_cycle", drop_cyc, 16);
    check_int("lim_grant1_cycle", g1_cyc, 18);
`endif
    busreq = '0; busidle = '1; step("lim_rel"); step("lim_gap");

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset   = ($urandom_range(0, 199) == 0);
      busreq  = 3'($urandom);
      busidle = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b111;
      if ($urandom_range(0, 3) == 0) busidle = 3'b000;
      step($sformatf("rnd%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
